tnn_feature_packer: RTL and testbench

TNN_FEATURE_PACKER -- requirements
Module: tnn_feature_packer

---
 rtl/tnn_pkg.sv | 18 +
 rtl/tnn_quant3.sv | 18 +
 rtl/tnn_feature_packer.sv | 118 +++++++++++
 tb/tb_tnn_feature_packer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared constants, FSM state type and default threshold table for the TNN feature packer.
package tnn_pkg;

  localparam int unsigned DW     = 8;
  localparam int unsigned NFEAT  = 7;
  localparam int unsigned NLEVEL = 3;

  typedef enum logic [0:0] {
    StFill,
    StFull
  } state_e;

  // Default thresholds are the same for every feature: 64, 128, 192.
  function automatic int unsigned thr_default(input int unsigned level);
    return 64 * (level + 1);
  endfunction

endpackage

// File: rtl/tnn_quant3.sv
// Three-level quantizer: counts how many thresholds the sample meets or exceeds (q in 0..3).
module tnn_quant3 #(
  parameter int unsigned DW = tnn_pkg::DW
) (
  input  logic [DW-1:0]                        data,
  input  logic [tnn_pkg::NLEVEL-1:0][DW-1:0]   thr,
  output logic [1:0]                           q
);

  // Levels are counted independently, so non-monotonic thresholds are allowed.
  always_comb begin
    q = '0;
    for (int k = 0; k < int'(tnn_pkg::NLEVEL); k++) begin
      if (data >= thr[k]) q = q + 2'd1;
    end
  end

endmodule

// File: rtl/tnn_feature_packer.sv
// Quantizes a stream of raw features and packs each group of seven into one output frame,
// with frame resync on in_first and a writable per-feature threshold table.
module tnn_feature_packer #(
  parameter int unsigned DW    = tnn_pkg::DW,
  parameter int unsigned NFEAT = tnn_pkg::NFEAT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_first,
  input  logic          thr_we,
  input  logic [4:0]    thr_idx,
  input  logic [DW-1:0] thr_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_a,
  output logic [1:0]    out_b,
  output logic [1:0]    out_c,
  output logic [1:0]    out_d,
  output logic [1:0]    out_e,
  output logic [1:0]    out_f,
  output logic [1:0]    out_g,
  output logic          frame_err
);

  import tnn_pkg::*;

  localparam int unsigned IW   = $clog2(NFEAT);
  localparam int unsigned NTHR = NFEAT * NLEVEL;
  localparam int unsigned TIW  = $clog2(NTHR);

  state_e                    state_q;
  logic [IW-1:0]             idx_q;
  logic [1:0]                asm_q [NFEAT];
  logic [1:0]                out_q [NFEAT];
  logic                      out_valid_q;
  logic                      frame_err_q;
  logic [DW-1:0]             thr_q [NTHR];

  logic                      accept;
  logic                      resync;
  logic                      load;
  logic [IW-1:0]             feat;
  logic [NLEVEL-1:0][DW-1:0] thr_sel;
  logic [1:0]                q;

  assign in_ready = (state_q == StFill);
  assign accept   = in_valid && in_ready;
  assign resync   = accept && in_first && (idx_q != '0);
  // A beat flagged in_first is always feature a, whatever the current index.
  assign feat     = in_first ? '0 : idx_q;
  assign load     = (state_q == StFull) && (!out_valid_q || out_ready);

  always_comb begin
    thr_sel = '0;
    for (int k = 0; k < int'(NLEVEL); k++) begin
      thr_sel[k] = thr_q[TIW'(NLEVEL * 32'(feat) + 32'(k))];
    end
  end

  tnn_quant3 #(
    .DW (DW)
  ) u_quant (
    .data (in_data),
    .thr  (thr_sel),
    .q    (q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < int'(NFEAT); i++) begin
        asm_q[i] <= '0;
        out_q[i] <= '0;
      end
      for (int i = 0; i < int'(NTHR); i++) begin
        thr_q[i] <= DW'(thr_default(i % NLEVEL));
      end
    end else begin
      frame_err_q <= resync;
      if (thr_we && (32'(thr_idx) < NTHR)) thr_q[TIW'(thr_idx)] <= thr_data;
      if (accept) begin
        if (resync) begin
          asm_q[0] <= q;
          idx_q    <= IW'(1);
        end else begin
          asm_q[idx_q] <= q;
          if (idx_q == IW'(NFEAT - 1)) state_q <= StFull;
          else                         idx_q   <= idx_q + IW'(1);
        end
      end
      if (load) begin
        out_q       <= asm_q;
        out_valid_q <= 1'b1;
        idx_q       <= '0;
        state_q     <= StFill;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign out_a     = out_q[0];
  assign out_b     = out_q[1];
  assign out_c     = out_q[2];
  assign out_d     = out_q[3];
  assign out_e     = out_q[4];
  assign out_f     = out_q[5];
  assign out_g     = out_q[6];

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Directed, table-driven bench for tnn_feature_packer with hand-computed expected frames.
module tb_tnn_feature_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_first;
  logic [7:0] in_data;
  logic       thr_we;
  logic [4:0] thr_idx;
  logic [7:0] thr_data;
  logic       out_valid, out_ready;
  logic [1:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g;
  logic       frame_err;

  int total = 0;
  int pass  = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] exp;
  } vec_t;
  vec_t vec [14];

  always #5 clk = ~clk;

  tnn_feature_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .thr_we    (thr_we),
    .thr_idx   (thr_idx),
    .thr_data  (thr_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_g     (out_g),
    .frame_err (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [13:0] outs();
    return {out_a, out_b, out_c, out_d, out_e, out_f, out_g};
  endfunction

  function automatic logic [1:0] get_out(input int i);
    case (i)
      0: return out_a;
      1: return out_b;
      2: return out_c;
      3: return out_d;
      4: return out_e;
      5: return out_f;
      default: return out_g;
    endcase
  endfunction

  function automatic logic [13:0] pack_exp(input int base);
    logic [13:0] e;
    e = '0;
    for (int i = 0; i < 7; i++) e = {e[11:0], vec[base + i].exp};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and return 1 ns after the edge that accepts it.
  task automatic send(input logic [7:0] d, input logic f);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 after %0d cycles", n);
    end
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic send_table(input int base);
    for (int i = 0; i < 7; i++) send(vec[base + i].data, i == 0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    check("consume_clears_valid", out_valid, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    vec[0]  = '{8'd0,   2'd0};
    vec[1]  = '{8'd63,  2'd0};
    vec[2]  = '{8'd64,  2'd1};
    vec[3]  = '{8'd127, 2'd1};
    vec[4]  = '{8'd128, 2'd2};
    vec[5]  = '{8'd191, 2'd2};
    vec[6]  = '{8'd255, 2'd3};
    vec[7]  = '{8'd255, 2'd3};
    vec[8]  = '{8'd192, 2'd3};
    vec[9]  = '{8'd191, 2'd2};
    vec[10] = '{8'd65,  2'd1};
    vec[11] = '{8'd64,  2'd1};
    vec[12] = '{8'd0,   2'd0};
    vec[13] = '{8'd200, 2'd3};

    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_data = '0;
    thr_we = 1'b0; thr_idx = '0; thr_data = '0; out_ready = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_outs", outs(), 14'd0);
    rst_n = 1'b1;
    tick();

    // Basic quantization with defaults and output latency.
    for (int fr = 0; fr < 2; fr++) begin
      send_table(fr * 7);
      check("lat_not_yet", out_valid, 1'b0);
      check("full_in_ready_low", in_ready, 1'b0);
      tick();
      check("lat_valid", out_valid, 1'b1);
      check("refill_in_ready", in_ready, 1'b1);
      for (int i = 0; i < 7; i++) check("quant_feature", get_out(i), vec[fr * 7 + i].exp);
      consume();
    end

    // Backpressure across two frames.
    send_table(0);
    tick();
    check("bp_first_valid", out_valid, 1'b1);
    for (int i = 0; i < 7; i++) begin
      send(vec[7 + i].data, i == 0);
      if (i == 3) check("bp_hold_mid", outs(), pack_exp(0));
    end
    repeat (2) tick();
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_valid_held", out_valid, 1'b1);
    check("bp_hold_end", outs(), pack_exp(0));
    out_ready = 1'b1;
    tick();
    check("bp_second_valid", out_valid, 1'b1);
    check("bp_second_frame", outs(), pack_exp(7));
    check("bp_ready_back", in_ready, 1'b1);
    tick();
    check("bp_drained", out_valid, 1'b0);
    out_ready = 1'b0;

    // Resync on the 4th beat.
    send(8'd255, 1'b1);
    check("first_at_zero_no_err", frame_err, 1'b0);
    send(8'd255, 1'b0);
    send(8'd255, 1'b0);
    send(8'd0, 1'b1);
    check("resync_err_pulse", frame_err, 1'b1);
    tick();
    check("resync_err_one_cycle", frame_err, 1'b0);
    check("resync_no_output", out_valid, 1'b0);
    send(8'd64, 1'b0);
    send(8'd128, 1'b0);
    send(8'd192, 1'b0);
    send(8'd255, 1'b0);
    send(8'd0, 1'b0);
    send(8'd100, 1'b0);
    tick();
    check("resync_valid", out_valid, 1'b1);
    check("resync_frame", outs(), {2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1});
    consume();

    // Threshold write on the same edge as feature a uses the old threshold.
    thr_we = 1'b1; thr_idx = 5'd0; thr_data = 8'd10;
    in_valid = 1'b1; in_data = 8'd20; in_first = 1'b1;
    tick();
    thr_we = 1'b0; in_valid = 1'b0; in_first = 1'b0;
    for (int i = 0; i < 6; i++) send(8'd20, 1'b0);
    tick();
    check("thr_old_out_a", out_a, 2'd0);
    check("thr_old_frame", outs(), 14'd0);
    consume();
    for (int i = 0; i < 7; i++) send(8'd20, i == 0);
    tick();
    check("thr_new_out_a", out_a, 2'd1);
    check("thr_new_frame", outs(), {2'd1, 12'd0});
    consume();

    // Out-of-range writes ignored, index 20 is the last writable entry.
    thr_we = 1'b1;
    thr_idx = 5'd25; thr_data = 8'd255; tick();
    thr_idx = 5'd21; thr_data = 8'd255; tick();
    thr_idx = 5'd20; thr_data = 8'd250; tick();
    thr_we = 1'b0;
    for (int i = 0; i < 7; i++) send(8'd200, i == 0);
    tick();
    check("thr_range_frame", outs(), {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2});
    consume();

    // Asynchronous reset mid-frame with an unaccepted output pending.
    send_table(0);
    tick();
    check("pre_rst_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) send(vec[7 + i].data, i == 0);
    rst_n = 1'b0;
    #2;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_outs", outs(), 14'd0);
    check("async_rst_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    send(8'd20, 1'b0);
    send(8'd63, 1'b0);
    send(8'd64, 1'b0);
    send(8'd127, 1'b0);
    send(8'd128, 1'b0);
    send(8'd191, 1'b0);
    send(8'd200, 1'b0);
    tick();
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_frame", outs(), {2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3});
    consume();

    // Continuous streaming: one frame per 8 cycles, in_ready low only in the FULL cycle.
    out_ready = 1'b1;
    b = 0;
    for (int c = 0; c < 24; c++) begin
      int fr, ft;
      fr = b / 7;
      ft = b % 7;
      in_valid = 1'b1;
      in_data  = vec[(fr % 2) * 7 + ft].data;
      in_first = (ft == 0);
      check("stream_in_ready", in_ready, (c % 8) != 7);
      check("stream_out_valid", out_valid, (c >= 8) && (c % 8 == 0));
      if (c >= 8 && c % 8 == 0) check("stream_frame", outs(), pack_exp(((c / 8 - 1) % 2) * 7));
      if (in_ready) b++;
      tick();
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    check("stream_last_valid", out_valid, 1'b1);
    check("stream_last_frame", outs(), pack_exp(0));
    tick();
    check("stream_drained", out_valid, 1'b0);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
